// File: rtl/demux_pkg.sv
// Shared types and defaults for the round-robin 1:2 word demultiplexer.
// Optional feature macro: DEMUX_WORD_COUNT_EN (per-lane pop counters and balance flag).
package demux_pkg;

    localparam int unsigned WIDTH_DEFAULT = 4;
    localparam int unsigned DEPTH_DEFAULT = 2;

    typedef enum logic {
        LANE0 = 1'b0,
        LANE1 = 1'b1
    } lane_t;

    typedef logic [WIDTH_DEFAULT-1:0] word_t;

endpackage

// File: rtl/demux_rr_cuatrobits_if.sv
// Upstream word handshake plus the two lane handshakes of the demultiplexer.
// Optional feature macro: DEMUX_WORD_COUNT_EN adds count0/count1/mismatch.
interface demux_rr_cuatrobits_if
    import demux_pkg::*;
#(
    parameter int unsigned WIDTH = WIDTH_DEFAULT
);

    logic             valid_in;
    logic [WIDTH-1:0] data_in;
    logic             ready_in;
    logic             ready0;
    logic             valid_out0;
    logic [WIDTH-1:0] data_out0;
    logic             ready1;
    logic             valid_out1;
    logic [WIDTH-1:0] data_out1;
    logic             selector;
`ifdef DEMUX_WORD_COUNT_EN
    logic [7:0]       count0;
    logic [7:0]       count1;
    logic             mismatch;
`endif

    // Environment side: produces the serial stream and consumes both lanes.
    modport master (
        output valid_in,
        output data_in,
        input  ready_in,
        output ready0,
        input  valid_out0,
        input  data_out0,
        output ready1,
        input  valid_out1,
        input  data_out1,
`ifdef DEMUX_WORD_COUNT_EN
        input  count0,
        input  count1,
        input  mismatch,
`endif
        input  selector
    );

    // Demultiplexer side.
    modport slave (
        input  valid_in,
        input  data_in,
        output ready_in,
        input  ready0,
        output valid_out0,
        output data_out0,
        input  ready1,
        output valid_out1,
        output data_out1,
`ifdef DEMUX_WORD_COUNT_EN
        output count0,
        output count1,
        output mismatch,
`endif
        output selector
    );

endinterface

// File: rtl/lane_fifo.sv
// Per-lane synchronous FIFO; head reads as zero while empty, no same-cycle fall-through.
module lane_fifo #(
    parameter int unsigned WIDTH = 4,
    parameter int unsigned DEPTH = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic             full,
    output logic             empty,
    output logic [WIDTH-1:0] head
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = $clog2(DEPTH) + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic             do_push;
    logic             do_pop;

    assign full    = (count_q == CW'(DEPTH));
    assign empty   = (count_q == '0);
    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;
    assign head    = empty ? '0 : mem_q[rd_ptr_q];

    // DEPTH is a power of two, so pointer overflow is the modulo wrap.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) begin
            wr_ptr_d = wr_ptr_q + PW'(1);
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + PW'(1);
        end
        unique case ({do_push, do_pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage needs no reset: stale entries are never visible once count is zero.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= push_data;
        end
    end

endmodule

// File: rtl/demux_rr_cuatrobits.sv
// Clocked 1:2 round-robin demultiplexer with a small FIFO and handshake per lane.
// Optional feature macro: DEMUX_WORD_COUNT_EN (per-lane pop counters and balance flag).
module demux_rr_cuatrobits
    import demux_pkg::*;
#(
    parameter int unsigned WIDTH = WIDTH_DEFAULT,
    parameter int unsigned DEPTH = DEPTH_DEFAULT
) (
    input  logic                  clk,
    input  logic                  reset,
    demux_rr_cuatrobits_if.slave  bus
);

    lane_t      sel_q, sel_d;
    logic       full0, full1;
    logic       empty0, empty1;
    logic       ready_int;
    logic       accept;
    logic       push0, push1;
    logic       pop0, pop1;

    // Only the selected lane gates acceptance; no path from the lane ready inputs.
    assign ready_int = (sel_q == LANE0) ? ~full0 : ~full1;
    assign accept    = bus.valid_in & ready_int;
    assign push0     = accept & (sel_q == LANE0);
    assign push1     = accept & (sel_q == LANE1);
    assign pop0      = ~empty0 & bus.ready0;
    assign pop1      = ~empty1 & bus.ready1;

    always_comb begin
        sel_d = sel_q;
        if (accept) begin
            sel_d = (sel_q == LANE0) ? LANE1 : LANE0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            sel_q <= LANE0;
        end else begin
            sel_q <= sel_d;
        end
    end

    lane_fifo #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_lane0 (
        .clk       (clk),
        .reset     (reset),
        .push      (push0),
        .push_data (bus.data_in),
        .pop       (pop0),
        .full      (full0),
        .empty     (empty0),
        .head      (bus.data_out0)
    );

    lane_fifo #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_lane1 (
        .clk       (clk),
        .reset     (reset),
        .push      (push1),
        .push_data (bus.data_in),
        .pop       (pop1),
        .full      (full1),
        .empty     (empty1),
        .head      (bus.data_out1)
    );

    assign bus.ready_in   = ready_int;
    assign bus.valid_out0 = ~empty0;
    assign bus.valid_out1 = ~empty1;
    assign bus.selector   = sel_q;

`ifdef DEMUX_WORD_COUNT_EN
    logic [7:0] count0_q, count0_d;
    logic [7:0] count1_q, count1_d;
    logic [7:0] diff;

    always_comb begin
        count0_d = count0_q;
        count1_d = count1_q;
        if (pop0) begin
            count0_d = count0_q + 8'd1;
        end
        if (pop1) begin
            count1_d = count1_q + 8'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            count0_q <= '0;
            count1_q <= '0;
        end else begin
            count0_q <= count0_d;
            count1_q <= count1_d;
        end
    end

    // Modulo-256 distance: balanced means the difference is -1, 0 or +1.
    assign diff         = count0_q - count1_q;
    assign bus.count0   = count0_q;
    assign bus.count1   = count1_q;
    assign bus.mismatch = (diff != 8'd0) && (diff != 8'd1) && (diff != 8'd255);
`endif

endmodule

// File: tb/tb_demux_rr_cuatrobits.sv
// Directed self-checking bench for demux_rr_cuatrobits; counter checks build with DEMUX_WORD_COUNT_EN.
module tb_demux_rr_cuatrobits;
    import demux_pkg::*;

    logic clk;
    logic reset;
    int   checks;
    int   failures;

    demux_rr_cuatrobits_if #(.WIDTH(WIDTH_DEFAULT)) bus ();

    demux_rr_cuatrobits #(
        .WIDTH (WIDTH_DEFAULT),
        .DEPTH (DEPTH_DEFAULT)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one rising edge; outputs are sampled 1 time unit later.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_lanes(input string tag, input logic v0, input word_t d0,
                               input logic v1, input word_t d1, input logic sel);
        check({tag, ".valid_out0"}, 32'(bus.valid_out0), 32'(v0));
        check({tag, ".data_out0"},  32'(bus.data_out0),  32'(d0));
        check({tag, ".valid_out1"}, 32'(bus.valid_out1), 32'(v1));
        check({tag, ".data_out1"},  32'(bus.data_out1),  32'(d1));
        check({tag, ".selector"},   32'(bus.selector),   32'(sel));
    endtask

    initial begin
        checks       = 0;
        failures     = 0;
        reset        = 1'b1;
        bus.valid_in = 1'b0;
        bus.data_in  = '0;
        bus.ready0   = 1'b0;
        bus.ready1   = 1'b0;

        // Reset then idle
        tick();
        tick();
        reset = 1'b0;
        check_lanes("reset", 1'b0, 4'h0, 1'b0, 4'h0, 1'b0);
        check("reset.ready_in", 32'(bus.ready_in), 32'd1);
        tick();
        check("idle.ready_in", 32'(bus.ready_in), 32'd1);

        // Streaming with both lanes ready
        bus.ready0 = 1'b1; bus.ready1 = 1'b1;
        bus.valid_in = 1'b1; bus.data_in = 4'h1;
        tick(); check_lanes("stream1", 1'b1, 4'h1, 1'b0, 4'h0, 1'b1);
        bus.data_in = 4'h2;
        tick(); check_lanes("stream2", 1'b0, 4'h0, 1'b1, 4'h2, 1'b0);
        bus.data_in = 4'h3;
        tick(); check_lanes("stream3", 1'b1, 4'h3, 1'b0, 4'h0, 1'b1);
        bus.data_in = 4'h4;
        tick(); check_lanes("stream4", 1'b0, 4'h0, 1'b1, 4'h4, 1'b0);
        bus.valid_in = 1'b0;
        tick(); check_lanes("stream_drain", 1'b0, 4'h0, 1'b0, 4'h0, 1'b0);

        // Backpressure on lane 0
        bus.ready0 = 1'b0;
        bus.valid_in = 1'b1; bus.data_in = 4'hA;
        tick(); check_lanes("bp_a", 1'b1, 4'hA, 1'b0, 4'h0, 1'b1);
        check("bp_a.ready_in", 32'(bus.ready_in), 32'd1);
        bus.data_in = 4'hB;
        tick(); check_lanes("bp_b", 1'b1, 4'hA, 1'b1, 4'hB, 1'b0);
        check("bp_b.ready_in", 32'(bus.ready_in), 32'd1);
        bus.data_in = 4'hC;
        tick(); check_lanes("bp_c", 1'b1, 4'hA, 1'b0, 4'h0, 1'b1);
        bus.data_in = 4'hD;
        tick(); check_lanes("bp_d", 1'b1, 4'hA, 1'b1, 4'hD, 1'b0);
        check("bp_d.ready_in", 32'(bus.ready_in), 32'd0);
        bus.data_in = 4'hE;
        tick(); check_lanes("bp_e_held", 1'b1, 4'hA, 1'b0, 4'h0, 1'b0);
        check("bp_e_held.ready_in", 32'(bus.ready_in), 32'd0);
        tick(); check("bp_e_held2.ready_in", 32'(bus.ready_in), 32'd0);
        check("bp_e_held2.selector", 32'(bus.selector), 32'd0);
        bus.ready0 = 1'b1;
        tick(); check_lanes("bp_pop_a", 1'b1, 4'hC, 1'b0, 4'h0, 1'b0);
        check("bp_pop_a.ready_in", 32'(bus.ready_in), 32'd1);
        tick(); check_lanes("bp_e_acc", 1'b1, 4'hE, 1'b0, 4'h0, 1'b1);
        bus.data_in = 4'hF;
        tick(); check_lanes("bp_f", 1'b0, 4'h0, 1'b1, 4'hF, 1'b0);
        bus.valid_in = 1'b0;
        tick(); check_lanes("bp_drain", 1'b0, 4'h0, 1'b0, 4'h0, 1'b0);

        // Gap in valid_in: selector holds
        bus.ready0 = 1'b0; bus.ready1 = 1'b0;
        bus.valid_in = 1'b1; bus.data_in = 4'h5;
        tick(); check_lanes("gap_5", 1'b1, 4'h5, 1'b0, 4'h0, 1'b1);
        bus.valid_in = 1'b0; bus.data_in = 4'h7;
        tick(); check_lanes("gap_idle1", 1'b1, 4'h5, 1'b0, 4'h0, 1'b1);
        tick(); check_lanes("gap_idle2", 1'b1, 4'h5, 1'b0, 4'h0, 1'b1);
        bus.valid_in = 1'b1; bus.data_in = 4'h9;
        tick(); check_lanes("gap_9", 1'b1, 4'h5, 1'b1, 4'h9, 1'b0);

        // Fill both lanes, then reset mid-operation
        bus.data_in = 4'h6;
        tick(); check("fill.selector", 32'(bus.selector), 32'd1);
        bus.data_in = 4'h8;
        tick(); check("fill.ready_in", 32'(bus.ready_in), 32'd0);
        check_lanes("fill", 1'b1, 4'h5, 1'b1, 4'h9, 1'b0);
        bus.valid_in = 1'b0;
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check_lanes("midreset", 1'b0, 4'h0, 1'b0, 4'h0, 1'b0);
        check("midreset.ready_in", 32'(bus.ready_in), 32'd1);
        bus.valid_in = 1'b1; bus.data_in = 4'h3;
        tick(); check_lanes("after_reset", 1'b1, 4'h3, 1'b0, 4'h0, 1'b1);
        bus.valid_in = 1'b0;

`ifdef DEMUX_WORD_COUNT_EN
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("cnt_reset.count0", 32'(bus.count0), 32'd0);
        check("cnt_reset.count1", 32'(bus.count1), 32'd0);
        check("cnt_reset.mismatch", 32'(bus.mismatch), 32'd0);
        // Lane 0 drains, lane 1 stalls: three pops on lane 0
        bus.ready0 = 1'b1; bus.ready1 = 1'b0;
        bus.valid_in = 1'b1;
        bus.data_in = 4'h1; tick();
        bus.data_in = 4'h2; tick();
        bus.data_in = 4'h3; tick();
        bus.data_in = 4'h4; tick();
        bus.data_in = 4'h5; tick();
        bus.valid_in = 1'b0;
        tick();
        check("cnt_a.count0", 32'(bus.count0), 32'd3);
        check("cnt_a.count1", 32'(bus.count1), 32'd0);
        check("cnt_a.mismatch", 32'(bus.mismatch), 32'd1);
        bus.ready0 = 1'b0; bus.ready1 = 1'b1;
        tick();
        check("cnt_b.count0", 32'(bus.count0), 32'd3);
        check("cnt_b.count1", 32'(bus.count1), 32'd1);
        check("cnt_b.mismatch", 32'(bus.mismatch), 32'd1);
        tick();
        check("cnt_c.count1", 32'(bus.count1), 32'd2);
        check("cnt_c.mismatch", 32'(bus.mismatch), 32'd0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
